// File: rtl/up_down_counter_pkg.sv
// Shared constants and next-value helper for up_down_counter.
// Build option: define UP_DOWN_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
package up_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

`ifdef UP_DOWN_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // All-ones value for a counter of the given width (1..32).
  function automatic logic [31:0] max_value(input int unsigned width);
    logic [63:0] one_hot;
    one_hot = 64'd1 << width;
    return 32'(one_hot - 64'd1);
  endfunction

  // Values are carried zero-extended to 32 bits so one helper serves every WIDTH.
  function automatic logic [31:0] next_count(
    input logic [31:0] cur,
    input logic        up,
    input logic        en,
    input int unsigned width,
    input bit          sat
  );
    logic [31:0] top;
    logic [31:0] nxt;
    top = max_value(width);
    nxt = cur;
    if (en) begin
      if (up == DIR_UP) begin
        if (sat && (cur == top)) nxt = cur;
        else                     nxt = (cur + 32'd1) & top;
      end else begin
        if (sat && (cur == 32'd0)) nxt = cur;
        else                       nxt = (cur - 32'd1) & top;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/up_down_counter_next.sv
// Combinational step logic: next count from current count, direction and enable.
// Wrap vs. saturate is selected by UP_DOWN_COUNTER_SATURATE_EN through the package.
module up_down_counter_next
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_down_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_next_o
);

  logic [31:0] count_ext;
  logic [31:0] next_ext;

  always_comb begin
    count_ext              = '0;
    count_ext[WIDTH-1:0]   = count_i;
    next_ext               = next_count(count_ext, up_down_i, enable_i, WIDTH, SATURATE);
  end

  assign count_next_o = next_ext[WIDTH-1:0];

  // The helper masks to WIDTH, so the upper bits are always zero.
  generate
    if (WIDTH < 32) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^next_ext[31:WIDTH];
    end
  endgenerate

endmodule

// File: rtl/up_down_counter.sv
// Up/down counter with synchronous reset, parallel load and count enable.
// Build option: UP_DOWN_COUNTER_SATURATE_EN selects saturating instead of wrapping counts.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] RESET_COUNT = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_d;

  up_down_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i      (count_q),
    .up_down_i    (up_down),
    .enable_i     (enable),
    .count_next_o (step_d)
  );

  // Load beats counting; reset beats both and is applied in the register itself.
  always_comb begin
    count_d = step_d;
    if (set) count_d = set_value;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= RESET_COUNT;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter: a reference model pushes expectations, each test pops and compares.
// Covers the wrap build by default and the saturating build when UP_DOWN_COUNTER_SATURATE_EN is defined.
module tb_up_down_counter;

  localparam int W = 4;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         set = 1'b0;
  logic [W-1:0] set_value = '0;
  logic         up_down = 1'b0;
  logic [W-1:0] count;

  logic [W-1:0] model_q;
  logic [W-1:0] exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  up_down_counter #(
    .WIDTH       (W),
    .RESET_VALUE (32'd0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .set       (set),
    .set_value (set_value),
    .up_down   (up_down),
    .count     (count)
  );

  // Drive one cycle of stimulus on the falling edge, predict, then wait until just after the rising edge.
  task automatic drive_cycle(input logic r, input logic s, input logic [W-1:0] sv,
                             input logic en, input logic ud);
    int nxt;
    @(negedge clk);
    reset = r; set = s; set_value = sv; enable = en; up_down = ud;
    if (r)        nxt = 0;
    else if (s)   nxt = int'(sv);
    else if (!en) nxt = int'(model_q);
    else if (ud) begin
      if (SAT_BUILD && int'(model_q) == 15) nxt = 15;
      else                                  nxt = (int'(model_q) + 1) % 16;
    end else begin
      if (SAT_BUILD && int'(model_q) == 0)  nxt = 0;
      else                                  nxt = (int'(model_q) + 15) % 16;
    end
    model_q = W'(nxt);
    exp_q.push_back(model_q);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL reset_hold[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d reset_hold[%0d]: count=%b", vectors, i, count);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL reset_release[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d reset_release[%0d]: count=%b", vectors, i, count);
    end
  endtask

  task automatic test_load_priority();
    logic [W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL load_over_enable[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d load_over_enable[%0d]: count=%b", vectors, i, count);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 4'b0101, 1'b0, 1'(i));
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL hold_disabled[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d hold_disabled[%0d]: count=%b", vectors, i, count);
    end
  endtask

  task automatic test_count_down();
    logic [W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL count_down[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d count_down[%0d]: count=%b", vectors, i, count);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'(i + 1));
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL dir_toggle_hold[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d dir_toggle_hold[%0d]: count=%b", vectors, i, count);
    end
  endtask

  task automatic test_count_up();
    logic [W-1:0] exp;
    drive_cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    exp = exp_q.pop_front(); vectors++;
    if (count !== exp) begin miscompares++; $display("FAIL load_zero: count=%b expected=%b", count, exp); end
    else $display("vec %0d load_zero: count=%b", vectors, count);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 4'h0, (i < 4), 1'b1);
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL count_up[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d count_up[%0d]: count=%b", vectors, i, count);
    end
  endtask

  // Wrap build expects 0000 / 1111 after one step; saturating build expects the end values to stick.
  task automatic test_boundaries();
    logic [W-1:0] exp;
    for (int d = 0; d < 2; d++) begin
      drive_cycle(1'b0, 1'b1, (d == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'(d == 0));
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL edge_load[%0d]: count=%b expected=%b", d, count, exp); end
      else $display("vec %0d edge_load[%0d]: count=%b", vectors, d, count);
      for (int i = 0; i < 3; i++) begin
        drive_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'(d == 0));
        exp = exp_q.pop_front(); vectors++;
        if (count !== exp) begin miscompares++; $display("FAIL edge_step[%0d][%0d]: count=%b expected=%b", d, i, count, exp); end
        else $display("vec %0d edge_step[%0d][%0d]: count=%b", vectors, d, i, count);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive_cycle((i == 3), 1'b0, 4'h0, 1'b1, 1'b1);
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL reset_mid_count[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d reset_mid_count[%0d]: count=%b", vectors, i, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(($urandom_range(15) == 0), ($urandom_range(5) == 0), W'($urandom_range(15)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
      exp = exp_q.pop_front(); vectors++;
      if (count !== exp) begin miscompares++; $display("FAIL back_to_back[%0d]: count=%b expected=%b", i, count, exp); end
      else $display("vec %0d back_to_back[%0d]: count=%b", vectors, i, count);
    end
  endtask

  initial begin
    model_q = 'x;
    test_reset();
    test_load_priority();
    test_count_down();
    test_count_up();
    test_boundaries();
    test_reset_mid_count();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
